alu_operand_loader: RTL and testbench

- Upstream stage of the 4-bit Hack-style ALU. Lets an operator enter operands and control bits from 4 toggle switches and one push button, then holds them stable on the ALU inputs.
- Debounces the button and synchronises the switches. A 5-state FSM sequences capture of x, y, control-low {zx,nx,zy,ny} and control-high {f,no}.
- Drives registered x, y, zx, nx, zy, ny, f, no directly into the ALU.

---
 rtl/alu_operand_loader.sv | 107 ++++++++++
 tb/tb_alu_operand_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: switch/button operand entry front-end for the 4-bit Hack ALU
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_step,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       zx,
  output logic       nx,
  output logic       zy,
  output logic       ny,
  output logic       f,
  output logic       no,
  output logic [2:0] stage,
  output logic       ready
);
  typedef enum logic [2:0] {
    LOAD_X  = 3'd0,
    LOAD_Y  = 3'd1,
    LOAD_CL = 3'd2,
    LOAD_CH = 3'd3,
    SHOW    = 3'd4
  } state_t;
  logic             btn_s1_q, btn_s1_d, btn_sync_q, btn_sync_d;
  logic [3:0]       sw_s1_q, sw_s1_d, sw_sync_q, sw_sync_d;
  logic             btn_db_q, btn_db_d, btn_db_dly_q, btn_db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       x_q, x_d, y_q, y_d, cl_q, cl_d;
  logic [1:0]       ch_q, ch_d;
  logic             ready_q, ready_d;
  logic             step;
  // Two-flop synchronisers, debounce counter and rising-edge detect
  always_comb begin
    btn_s1_d     = btn_step;
    btn_sync_d   = btn_s1_q;
    sw_s1_d      = sw;
    sw_sync_d    = sw_s1_q;
    btn_db_d     = btn_db_q;
    cnt_d        = '0;
    btn_db_dly_d = btn_db_q;
    if (btn_sync_q != btn_db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) btn_db_d = btn_sync_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  assign step = btn_db_q & ~btn_db_dly_q;
  // Entry sequencer: each step captures the synchronised switches into the current field
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cl_d    = cl_q;
    ch_d    = ch_q;
    case (state_q)
      LOAD_X:  if (step) begin x_d  = sw_sync_q;      state_d = LOAD_Y;  end
      LOAD_Y:  if (step) begin y_d  = sw_sync_q;      state_d = LOAD_CL; end
      LOAD_CL: if (step) begin cl_d = sw_sync_q;      state_d = LOAD_CH; end
      LOAD_CH: if (step) begin ch_d = sw_sync_q[1:0]; state_d = SHOW;    end
      SHOW:    if (step) state_d = LOAD_X;
      default: state_d = LOAD_X;
    endcase
    ready_d = (state_d == SHOW);
  end
  // All state clears asynchronously so a reset discards any partial entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q     <= 1'b0;
      btn_sync_q   <= 1'b0;
      sw_s1_q      <= '0;
      sw_sync_q    <= '0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= LOAD_X;
      x_q          <= '0;
      y_q          <= '0;
      cl_q         <= '0;
      ch_q         <= '0;
      ready_q      <= 1'b0;
    end else begin
      btn_s1_q     <= btn_s1_d;
      btn_sync_q   <= btn_sync_d;
      sw_s1_q      <= sw_s1_d;
      sw_sync_q    <= sw_sync_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cl_q         <= cl_d;
      ch_q         <= ch_d;
      ready_q      <= ready_d;
    end
  end
  assign x                = x_q;
  assign y                = y_q;
  assign {zx, nx, zy, ny} = cl_q;
  assign {f, no}          = ch_q;
  assign stage            = state_q;
  assign ready            = ready_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed table-driven checks of the operand loader
module tb_alu_operand_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       btn_step = 1'b0;
  logic [3:0] x, y;
  logic       zx, nx, zy, ny, f, no, ready;
  logic [2:0] stage;
  int n_chk = 0;
  int n_fail = 0;

  alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_step(btn_step),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .stage(stage), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] cl;
    logic [1:0] ch;
    logic [2:0] st;
    logic       rdy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    cyc(4);
    btn_step = 1'b1;
    cyc(12);
    btn_step = 1'b0;
    cyc(12);
  endtask

  task automatic check_all(input string nm, input logic [3:0] ex, input logic [3:0] ey,
                           input logic [3:0] ecl, input logic [1:0] ech,
                           input logic [2:0] est, input logic erdy);
    chk({nm, " x"}, 8'(x), 8'(ex));
    chk({nm, " y"}, 8'(y), 8'(ey));
    chk({nm, " cl"}, 8'({zx, nx, zy, ny}), 8'(ecl));
    chk({nm, " ch"}, 8'({f, no}), 8'(ech));
    chk({nm, " stage"}, 8'(stage), 8'(est));
    chk({nm, " ready"}, 8'(ready), 8'(erdy));
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all(nm, 4'h0, 4'h0, 4'h0, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int bounce[22] = '{1, 2, 2, 1, 3, 3, 1, 1, 2, 2, 3, 1, 1, 3, 2, 2, 3, 2, 1, 1, 2, 1};

  initial begin
    vecs[0] = '{sw: 4'h8, x: 4'h8, y: 4'h0, cl: 4'b0000, ch: 2'b00, st: 3'd1, rdy: 1'b0};
    vecs[1] = '{sw: 4'h7, x: 4'h8, y: 4'h7, cl: 4'b0000, ch: 2'b00, st: 3'd2, rdy: 1'b0};
    vecs[2] = '{sw: 4'h4, x: 4'h8, y: 4'h7, cl: 4'b0100, ch: 2'b00, st: 3'd3, rdy: 1'b0};
    vecs[3] = '{sw: 4'h3, x: 4'h8, y: 4'h7, cl: 4'b0100, ch: 2'b11, st: 3'd4, rdy: 1'b1};
    vecs[4] = '{sw: 4'hF, x: 4'h8, y: 4'h7, cl: 4'b0100, ch: 2'b11, st: 3'd0, rdy: 1'b0};
    vecs[5] = '{sw: 4'h2, x: 4'h2, y: 4'h7, cl: 4'b0100, ch: 2'b11, st: 3'd1, rdy: 1'b0};
    vecs[6] = '{sw: 4'hD, x: 4'h2, y: 4'hD, cl: 4'b0100, ch: 2'b11, st: 3'd2, rdy: 1'b0};
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    async_reset("reset");
    cyc(50);
    check_all("idle50", 4'h0, 4'h0, 4'h0, 2'b00, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      press(vecs[i].sw);
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].cl, vecs[i].ch,
                vecs[i].st, vecs[i].rdy);
      if (i == 4) begin
        sw = 4'hF;
        cyc(100);
        check_all("hold_sw", 4'h8, 4'h7, 4'b0100, 2'b11, 3'd0, 1'b0);
      end
    end
    async_reset("reset2");
    sw = 4'hA;
    cyc(4);
    for (int i = 0; i < 22; i++) begin
      btn_step = (i % 2 == 0);
      cyc(bounce[i]);
    end
    btn_step = 1'b0;
    cyc(8);
    check_all("bounce_only", 4'h0, 4'h0, 4'h0, 2'b00, 3'd0, 1'b0);
    btn_step = 1'b1;
    cyc(10);
    btn_step = 1'b0;
    cyc(12);
    check_all("bounce_settle", 4'hA, 4'h0, 4'h0, 2'b00, 3'd1, 1'b0);
    async_reset("reset3");
    sw = 4'h5;
    cyc(4);
    btn_step = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1 chk($sformatf("lat_edge%0d", e), 8'(x), 8'h0);
    end
    @(posedge clk);
    #1 chk("lat_edge7", 8'(x), 8'h5);
    @(negedge clk);
    btn_step = 1'b0;
    cyc(12);
    chk("lat_stage", 8'(stage), 8'd1);
    press(4'h6);
    check_all("mid_pre", 4'h5, 4'h6, 4'h0, 2'b00, 3'd2, 1'b0);
    async_reset("mid_reset");
    press(4'h9);
    check_all("mid_post", 4'h9, 4'h0, 4'h0, 2'b00, 3'd1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
